// File: rtl/colparity_stream_if.sv
// Slice stream bundle for the column-parity block: input slice stream and transformed output stream.
// The block acts as slave on both streams; the producer/consumer side uses the master view.
interface colparity_stream_if;
   logic        in_valid;
   logic        in_ready;
   logic [24:0] in_slice;
   logic        out_valid;
   logic        out_ready;
   logic [24:0] out_slice;
   logic        out_last;

   modport slave (
      input  in_valid, in_slice, out_ready,
      output in_ready, out_valid, out_slice, out_last
   );

   modport master (
      output in_valid, in_slice, out_ready,
      input  in_ready, out_valid, out_slice, out_last
   );
endinterface

// File: rtl/colparity_stream.sv
// Buffers DEPTH 5x5 slices, then streams each slice XOR-ed with its neighbour column parities.
// Output appears the cycle after the last input slice; out_ready low freezes the output slice.
module colparity_stream #(
   parameter int DEPTH = 64,
   parameter bit WRAP  = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   colparity_stream_if.slave  s,
   output logic               busy
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   localparam logic [0:0] ST_LOAD = 1'b0;
   localparam logic [0:0] ST_EMIT = 1'b1;

   logic [0:0]    state;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] prev_ptr;
   logic          in_fire;
   logic          out_fire;

   logic [24:0] slice_mem [DEPTH];
   logic [4:0]  par_mem   [DEPTH];

   logic [24:0] cur_slice;
   logic [4:0]  cur_par;
   logic [4:0]  prev_par;
   logic [24:0] xform;

   function automatic logic [4:0] col_par(input logic [24:0] a);
      logic [4:0] p;
      for (int x = 0; x < 5; x++) begin
         p[x] = a[x] ^ a[5 + x] ^ a[10 + x] ^ a[15 + x] ^ a[20 + x];
      end
      return p;
   endfunction

   assign s.in_ready  = (state == ST_LOAD);
   assign s.out_valid = (state == ST_EMIT);
   assign busy        = (state == ST_EMIT);
   assign s.out_last  = (state == ST_EMIT) && (rd_ptr == LAST_PTR);

   assign in_fire  = s.in_valid  && s.in_ready;
   assign out_fire = s.out_valid && s.out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_LOAD;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (in_fire) begin
            if (wr_ptr == LAST_PTR) begin
               wr_ptr <= '0;
               state  <= ST_EMIT;
            end else begin
               wr_ptr <= wr_ptr + 1'b1;
            end
         end
         if (out_fire) begin
            if (rd_ptr == LAST_PTR) begin
               rd_ptr <= '0;
               state  <= ST_LOAD;
            end else begin
               rd_ptr <= rd_ptr + 1'b1;
            end
         end
      end
   end

   // Parity is stored alongside each slice so the emit side never recomputes a neighbour.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         slice_mem[wr_ptr] <= s.in_slice;
         par_mem[wr_ptr]   <= col_par(s.in_slice);
      end
   end

   assign prev_ptr  = (rd_ptr == '0) ? LAST_PTR : (rd_ptr - 1'b1);
   assign cur_slice = slice_mem[rd_ptr];
   assign cur_par   = par_mem[rd_ptr];

   always_comb begin
      prev_par = par_mem[prev_ptr];
      if (rd_ptr == '0 && !WRAP) begin
         prev_par = 5'b0;
      end
   end

   always_comb begin
      xform = '0;
      for (int y = 0; y < 5; y++) begin
         for (int x = 0; x < 5; x++) begin
            xform[5*y + x] = cur_slice[5*y + x] ^ cur_par[(x + 4) % 5] ^ prev_par[(x + 1) % 5];
         end
      end
   end

   assign s.out_slice = xform;

endmodule

// File: tb/tb_colparity_stream.sv
// Scoreboard bench: four instances (DEPTH/WRAP = 4/1, 4/0, 64/1, 1/1) driven one at a time.
module tb_colparity_stream;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid  [4];
   logic [24:0] in_slice  [4];
   logic        out_ready [4];
   logic        in_ready  [4];
   logic        out_valid [4];
   logic [24:0] out_slice [4];
   logic        out_last  [4];
   logic        busy      [4];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int D = (g == 2) ? 64 : ((g == 3) ? 1 : 4);
      localparam bit W = (g == 1) ? 1'b0 : 1'b1;
      colparity_stream_if u_if ();
      assign u_if.in_valid  = in_valid[g];
      assign u_if.in_slice  = in_slice[g];
      assign u_if.out_ready = out_ready[g];
      assign in_ready[g]    = u_if.in_ready;
      assign out_valid[g]   = u_if.out_valid;
      assign out_slice[g]   = u_if.out_slice;
      assign out_last[g]    = u_if.out_last;
      colparity_stream #(.DEPTH(D), .WRAP(W)) u_dut (
         .clk  (clk),
         .rst  (rst),
         .s    (u_if.slave),
         .busy (busy[g])
      );
   end

   typedef struct {
      int          idx;
      logic [24:0] dat;
      logic        last;
   } exp_t;

   exp_t        exp_q[$];
   logic [24:0] st [64];
   int          checks = 0;
   int          errors = 0;
   int          pop_cnt = 0;
   int          rdy_mode = 0;   // 0 always ready, 1 random, 2 never, 3 manual

   function automatic int depth_of(input int idx);
      return (idx == 2) ? 64 : ((idx == 3) ? 1 : 4);
   endfunction

   function automatic logic [4:0] cpar(input logic [24:0] a);
      logic [4:0] p = '0;
      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 5; x++)
            p[x] = p[x] ^ a[5*y + x];
      return p;
   endfunction

   // Reference: A ^ C[x-1][z] ^ C[x+1][z-1], z-1 taken cyclically or as zero parity.
   function automatic logic [24:0] model(input int z, input int d, input bit w);
      logic [4:0]  c;
      logic [4:0]  cp;
      logic [24:0] r;
      c  = cpar(st[z]);
      cp = (z > 0) ? cpar(st[z-1]) : (w ? cpar(st[d-1]) : 5'b0);
      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 5; x++)
            r[5*y + x] = st[z][5*y + x] ^ c[(x + 4) % 5] ^ cp[(x + 1) % 5];
      return r;
   endfunction

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            for (int i = 0; i < 4; i++) begin
               if (out_valid[i]) begin
                  checks++;
                  if (in_ready[i] !== 1'b0 || busy[i] !== 1'b1) begin
                     errors++;
                     $display("FAIL emit_flags inst %0d: in_ready=%b busy=%b, required 0/1", i, in_ready[i], busy[i]);
                  end
               end
               if (out_valid[i] && out_ready[i]) begin
                  checks++;
                  if (exp_q.size() == 0) begin
                     errors++;
                     $display("FAIL unexpected_out inst %0d: slice=%h with nothing expected", i, out_slice[i]);
                  end else begin
                     e = exp_q.pop_front();
                     pop_cnt++;
                     if (e.idx != i || out_slice[i] !== e.dat || out_last[i] !== e.last) begin
                        errors++;
                        $display("FAIL out_slice inst %0d: got %h last=%b, required inst %0d %h last=%b",
                                 i, out_slice[i], out_last[i], e.idx, e.dat, e.last);
                     end
                  end
               end
            end
         end
      end
   endtask

   task automatic ready_driver();
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 4; i++) begin
            case (rdy_mode)
               0: out_ready[i] = 1'b1;
               1: out_ready[i] = ($urandom_range(0, 3) != 0);
               2: out_ready[i] = 1'b0;
               default: ;
            endcase
         end
      end
   endtask

   task automatic feed(input int idx, input int gapmax);
      int d;
      int n;
      d = depth_of(idx);
      for (int k = 0; k < d; k++) begin
         for (int g = $urandom_range(0, gapmax); g > 0; g--) begin
            in_valid[idx] = 1'b0;
            in_slice[idx] = 25'($urandom);
            @(posedge clk);
            #1;
         end
         in_valid[idx] = 1'b1;
         in_slice[idx] = st[k];
         n = 0;
         while (!in_ready[idx] && n < 100) begin
            @(posedge clk);
            #1;
            n++;
         end
         if (!in_ready[idx]) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout inst %0d slice %0d: in_ready=0, required 1", idx, k);
         end
         @(posedge clk);
         #1;
      end
      in_valid[idx] = 1'b0;
      checks++;
      if (out_valid[idx] !== 1'b1 || in_ready[idx] !== 1'b0) begin
         errors++;
         $display("FAIL latency inst %0d: out_valid=%b in_ready=%b after last input, required 1/0",
                  idx, out_valid[idx], in_ready[idx]);
      end
   endtask

   task automatic push_expected(input int idx);
      exp_t e;
      int   d;
      d = depth_of(idx);
      for (int z = 0; z < d; z++) begin
         e.idx  = idx;
         e.dat  = model(z, d, idx != 1);
         e.last = (z == d - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic drain(input int idx);
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0 || in_ready[idx] !== 1'b1 || out_valid[idx] !== 1'b0) begin
         errors++;
         $display("FAIL drain inst %0d: pending=%0d in_ready=%b out_valid=%b, required 0/1/0",
                  idx, exp_q.size(), in_ready[idx], out_valid[idx]);
         exp_q.delete();
      end
   endtask

   task automatic run_state(input int idx, input int gapmax);
      push_expected(idx);
      feed(idx, gapmax);
      drain(idx);
   endtask

   task automatic set_impulse(input int pos, input logic [24:0] v);
      for (int z = 0; z < 64; z++) st[z] = '0;
      st[pos] = v;
   endtask

   task automatic set_random();
      for (int z = 0; z < 64; z++) st[z] = 25'($urandom);
   endtask

   initial begin
      logic [24:0] hold_s;
      logic        hold_l;
      int          base;
      int          n;

      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid[i]  = 1'b0;
         in_slice[i]  = '0;
         out_ready[i] = 1'b1;
      end
      fork
         monitor();
         ready_driver();
      join_none

      #12;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (in_ready[i] !== 1'b1 || out_valid[i] !== 1'b0 || out_last[i] !== 1'b0 || busy[i] !== 1'b0) begin
            errors++;
            $display("FAIL reset inst %0d: in_ready=%b out_valid=%b out_last=%b busy=%b, required 1/0/0/0",
                     i, in_ready[i], out_valid[i], out_last[i], busy[i]);
         end
      end
      #10 rst = 1'b0;
      @(posedge clk);
      #1;

      // Impulse and wrap boundary cases
      rdy_mode = 1;
      set_impulse(0, 25'h1);
      run_state(0, 2);
      set_impulse(3, 25'h1);
      run_state(0, 1);
      run_state(1, 1);

      // Full-depth instance: all-ones then random content
      rdy_mode = 0;
      for (int z = 0; z < 64; z++) st[z] = 25'h1FFFFFF;
      run_state(2, 0);
      rdy_mode = 1;
      set_random();
      run_state(2, 2);

      // Backpressure at rd_ptr=1 with in_valid asserted during EMIT
      rdy_mode = 3;
      out_ready[0] = 1'b0;
      set_random();
      push_expected(0);
      feed(0, 2);
      out_ready[0] = 1'b1;
      @(posedge clk);
      #1;
      out_ready[0] = 1'b0;
      in_valid[0]  = 1'b1;
      in_slice[0]  = 25'($urandom);
      hold_s = out_slice[0];
      hold_l = out_last[0];
      base = pop_cnt;
      checks++;
      if (exp_q.size() == 0 || hold_s !== exp_q[0].dat || hold_l !== 1'b0) begin
         errors++;
         $display("FAIL bp_slice1: got %h last=%b, required next expected slice, last=0", hold_s, hold_l);
      end
      repeat (5) begin
         @(posedge clk);
         #1;
         checks++;
         if (out_slice[0] !== hold_s || out_last[0] !== hold_l || pop_cnt != base || out_valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: slice=%h last=%b valid=%b pops=%0d, required %h/%b/1/%0d",
                     out_slice[0], out_last[0], out_valid[0], pop_cnt, hold_s, hold_l, base);
         end
      end
      in_valid[0] = 1'b0;
      rdy_mode = 1;
      drain(0);

      // Asynchronous reset in the middle of EMIT
      rdy_mode = 0;
      set_impulse(0, 25'h1);
      base = pop_cnt;
      push_expected(0);
      feed(0, 0);
      n = 0;
      while (pop_cnt < base + 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0 || pop_cnt < base + 2) begin
         errors++;
         $display("FAIL mid_reset: out_valid=%b in_ready=%b busy=%b pops=%0d, required 0/1/0/>=%0d",
                  out_valid[0], in_ready[0], busy[0], pop_cnt - base, 2);
      end
      exp_q.delete();
      @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1;
      rdy_mode = 1;
      run_state(0, 1);

      // Single-slice state, cyclic onto itself
      set_impulse(0, 25'h1);
      run_state(3, 1);
      for (int k = 0; k < 4; k++) begin
         set_random();
         run_state(3, 2);
      end

      // Random states on the small instances
      for (int k = 0; k < 6; k++) begin
         set_random();
         run_state(k % 2, 3);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
